// File: rtl/tdm_demux_1to4_if.sv
// tdm_demux_1to4_if: serial-in / frame-out bundle between a TDM link and the demux
interface tdm_demux_1to4_if #(
    parameter int LANES = 4,
    localparam int SEL_W = $clog2(LANES)
);
    logic             d_in;
    logic             in_valid;
    logic             frame_sync;
    logic [SEL_W-1:0] select;
    logic [LANES-1:0] d_out;
    logic             out_valid;
    logic             frame_err;

    modport master (
        output d_in, in_valid, frame_sync,
        input  select, d_out, out_valid, frame_err
    );

    modport slave (
        input  d_in, in_valid, frame_sync,
        output select, d_out, out_valid, frame_err
    );
endinterface

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: registered time-division 1-to-LANES demultiplexer with frame realignment
module tdm_demux_1to4 #(
    parameter int LANES = 4,
    localparam int SEL_W = $clog2(LANES)
) (
    input logic              clk,
    input logic              rst,
    tdm_demux_1to4_if.slave  bus
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    logic [SEL_W-1:0] sel, sel_n;
    logic [LANES-1:0] shadow, shadow_n;
    logic [LANES-1:0] dout, dout_n;
    logic             ov_n, fe_n, ov, fe;
    logic [LANES-1:0] filled;

    // next-state: sync realigns to slot 0, otherwise a valid bit fills the current slot
    always_comb begin
        sel_n    = sel;
        shadow_n = shadow;
        dout_n   = dout;
        ov_n     = 1'b0;
        fe_n     = 1'b0;
        filled   = shadow;
        filled[sel] = bus.d_in;
        if (bus.frame_sync) begin
            fe_n     = sel != '0;
            shadow_n = '0;
            sel_n    = '0;
            if (bus.in_valid) begin
                shadow_n[0] = bus.d_in;
                sel_n       = SEL_W'(1);
            end
        end else if (bus.in_valid) begin
            if (sel == LAST) begin
                dout_n   = filled;
                ov_n     = 1'b1;
                sel_n    = '0;
                shadow_n = '0;
            end else begin
                shadow_n = filled;
                sel_n    = sel + SEL_W'(1);
            end
        end
    end

    // state and output registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= '0;
            shadow <= '0;
            dout   <= '0;
            ov     <= 1'b0;
            fe     <= 1'b0;
        end else begin
            sel    <= sel_n;
            shadow <= shadow_n;
            dout   <= dout_n;
            ov     <= ov_n;
            fe     <= fe_n;
        end
    end

    assign bus.select    = sel;
    assign bus.d_out     = dout;
    assign bus.out_valid = ov;
    assign bus.frame_err = fe;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed self-checking bench for the 1-to-4 TDM demux
module tb_tdm_demux_1to4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tdm_demux_1to4_if #(.LANES(4)) bus ();

    tdm_demux_1to4 #(.LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic d);
        bus.in_valid   = v;
        bus.frame_sync = s;
        bus.d_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input logic ov, input logic fe);
        chk({tag, ".select"}, 32'(bus.select), s);
        chk({tag, ".d_out"}, 32'(bus.d_out), d);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
    endtask

    logic [7:0] b2b_bits;

    initial begin
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.d_in       = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 4'b0000, 0, 0);
        rst = 1'b0;

        step(1, 1, 1); chk_all("basic0", 1, 4'b0000, 0, 0);
        step(1, 0, 1); chk_all("basic1", 2, 4'b0000, 0, 0);
        step(1, 0, 0); chk_all("basic2", 3, 4'b0000, 0, 0);
        step(1, 0, 0); chk_all("basic3", 0, 4'b0011, 1, 0);
        step(0, 0, 0); chk_all("basic_idle", 0, 4'b0011, 0, 0);

        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk_all("gap0", 1, 4'b0011, 0, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        chk_all("gap1", 2, 4'b0011, 0, 0);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk_all("gap2", 3, 4'b0011, 0, 0);
        step(1, 0, 1); chk_all("gap3", 0, 4'b1010, 1, 0);
        step(0, 0, 0); chk_all("gap_idle", 0, 4'b1010, 0, 0);

        step(1, 0, 1); step(1, 0, 0);
        chk_all("resync_pre", 2, 4'b1010, 0, 0);
        step(1, 1, 1); chk_all("resync", 1, 4'b1010, 0, 1);
        step(1, 0, 1); chk_all("resync1", 2, 4'b1010, 0, 0);
        step(1, 0, 1); chk_all("resync2", 3, 4'b1010, 0, 0);
        step(1, 0, 1); chk_all("resync3", 0, 4'b1111, 1, 0);

        b2b_bits = 8'b1001_0101;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, b2b_bits[i]);
            chk($sformatf("b2b%0d.out_valid", i), 32'(bus.out_valid), (i == 3 || i == 7) ? 1 : 0);
            chk($sformatf("b2b%0d.select", i), 32'(bus.select), (i + 1) % 4);
            if (i == 3) chk("b2b_first.d_out", 32'(bus.d_out), 4'b0101);
            if (i == 7) chk("b2b_second.d_out", 32'(bus.d_out), 4'b1001);
        end

        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk_all("rst_mid_pre", 3, 4'b1001, 0, 0);
        rst = 1'b1;
        step(1, 1, 1);
        chk_all("rst_mid", 0, 4'b0000, 0, 0);
        rst = 1'b0;
        step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk_all("post_rst2", 3, 4'b0000, 0, 0);
        step(1, 0, 0); chk_all("post_rst3", 0, 4'b0110, 1, 0);

        step(1, 0, 1);
        step(0, 1, 0); chk_all("sync_nodata", 0, 4'b0110, 0, 1);
        step(0, 1, 0); chk_all("sync_aligned", 0, 4'b0110, 0, 0);
        step(0, 0, 0); chk_all("final_idle", 0, 4'b0110, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
